// File: rtl/ftdi_pkt_bridge_pkg.sv
// Shared state encodings and default timing for the FTDI packet bridge.
package ftdi_pkg;

  localparam int          DEF_PKT_LEN     = 1024;
  localparam logic [7:0]  DEF_PAD_BYTE    = 8'h01;
  localparam int          DEF_SYNC_STAGES = 2;
  localparam int          DEF_WR_LOW_CYC  = 2;
  localparam int          DEF_RD_LOW_CYC  = 2;
  localparam int          DEF_RECOVER_CYC = 2;

  // Bus cycle FSM
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_SETUP = 3'd1;
  localparam logic [2:0] WR_LOW   = 3'd2;
  localparam logic [2:0] RD_LOW   = 3'd3;
  localparam logic [2:0] RECOVER  = 3'd4;

  // Packet framer FSM
  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_DATA = 2'd1;
  localparam logic [1:0] F_PAD  = 2'd2;

endpackage

// File: rtl/ftdi_pkt_bridge_if.sv
// FTDI pins plus the tx packet stream and rx byte stream of the bridge.
interface ftdi_pkt_bridge_if #(parameter int LW = 11);
  logic          txe_n;
  logic          rxf_n;
  logic [7:0]    adbus_in;
  logic [7:0]    adbus_out;
  logic          adbus_oe;
  logic          ftdi_wr_n;
  logic          ftdi_rd_n;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          pkt_start;
  logic [LW-1:0] pkt_len;
  logic          pkt_busy;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (
    input  txe_n, rxf_n, adbus_in, tx_data, tx_valid, pkt_start, pkt_len, rx_ready,
    output adbus_out, adbus_oe, ftdi_wr_n, ftdi_rd_n, tx_ready, pkt_busy, rx_data, rx_valid
  );

  modport slave (
    output txe_n, rxf_n, adbus_in, tx_data, tx_valid, pkt_start, pkt_len, rx_ready,
    input  adbus_out, adbus_oe, ftdi_wr_n, ftdi_rd_n, tx_ready, pkt_busy, rx_data, rx_valid
  );
endinterface

// File: rtl/ftdi_pkt_framer.sv
// Turns a length-tagged tx byte stream into fixed PKT_LEN packets, padding short payloads.
module ftdi_pkt_framer
  import ftdi_pkg::*;
#(
  parameter int         PKT_LEN  = DEF_PKT_LEN,
  parameter logic [7:0] PAD_BYTE = DEF_PAD_BYTE,
  parameter int         LW       = $clog2(PKT_LEN + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          pkt_start,
  input  logic [LW-1:0] pkt_len,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          pkt_busy,
  output logic          byte_full,
  output logic [7:0]    byte_out,
  input  logic          wr_done
);

  localparam logic [LW-1:0] FULL_LEN = LW'(PKT_LEN);

  logic [1:0]    state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len;
  logic [LW-1:0] len_clip;

  assign len_clip = (pkt_len > FULL_LEN) ? FULL_LEN : pkt_len;
  assign tx_ready = (state == F_DATA) && !byte_full && (cnt != len);
  assign pkt_busy = (state != F_IDLE);

  // The byte register stays full for the whole bus write so adbus_out is stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= F_IDLE;
      cnt       <= '0;
      len       <= '0;
      byte_full <= 1'b0;
      byte_out  <= '0;
    end else if (clear) begin
      state     <= F_IDLE;
      cnt       <= '0;
      byte_full <= 1'b0;
    end else begin
      if (wr_done) byte_full <= 1'b0;
      case (state)
        F_IDLE: begin
          if (pkt_start) begin
            len   <= len_clip;
            cnt   <= '0;
            state <= (len_clip == '0) ? F_PAD : F_DATA;
          end
        end
        F_DATA: begin
          if (cnt == len) begin
            state <= F_PAD;
          end else if (tx_valid && tx_ready) begin
            byte_out  <= tx_data;
            byte_full <= 1'b1;
            cnt       <= cnt + 1'b1;
          end
        end
        F_PAD: begin
          if (cnt == FULL_LEN) begin
            if (!byte_full || wr_done) state <= F_IDLE;
          end else if (!byte_full) begin
            byte_out  <= PAD_BYTE;
            byte_full <= 1'b1;
            cnt       <= cnt + 1'b1;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ftdi_pkt_bridge.sv
// FTDI FIFO bus master: arbitrates read/write bus cycles between a one-byte rx slot and the packet framer.
module ftdi_pkt_bridge
  import ftdi_pkg::*;
#(
  parameter int         PKT_LEN     = DEF_PKT_LEN,
  parameter logic [7:0] PAD_BYTE    = DEF_PAD_BYTE,
  parameter int         SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int         WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int         RD_LOW_CYC  = DEF_RD_LOW_CYC,
  parameter int         RECOVER_CYC = DEF_RECOVER_CYC
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic rd_en,
  input  logic wr_en,
  ftdi_pkt_bridge_if.master bus
);

  localparam int LW = $clog2(PKT_LEN + 1);

  logic [SYNC_STAGES-1:0] txe_sync, rxf_sync;
  logic [2:0] state, state_nxt;
  logic [7:0] cyc, cyc_nxt;
  logic       last_wr;
  logic       grant_rd, grant_wr, wr_done, rd_cap;
  logic       rd_elig, wr_elig, pop;
  logic       fr_full;
  logic [7:0] fr_byte;
  logic       wr_n_q, rd_n_q, oe_q, rx_valid_q;
  logic [7:0] dout_q, rx_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txe_sync <= '1;
      rxf_sync <= '1;
    end else begin
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], bus.txe_n};
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], bus.rxf_n};
    end
  end

  ftdi_pkt_framer #(.PKT_LEN(PKT_LEN), .PAD_BYTE(PAD_BYTE), .LW(LW)) u_framer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .pkt_start (bus.pkt_start),
    .pkt_len   (bus.pkt_len),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready),
    .pkt_busy  (bus.pkt_busy),
    .byte_full (fr_full),
    .byte_out  (fr_byte),
    .wr_done   (wr_done)
  );

  assign pop     = rx_valid_q && bus.rx_ready;
  assign rd_elig = !rxf_sync[SYNC_STAGES-1] && rd_en && (!rx_valid_q || pop);
  assign wr_elig = !txe_sync[SYNC_STAGES-1] && wr_en && fr_full;

  // Arbitration only happens in IDLE, so a started cycle always runs to RECOVER.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    wr_done   = 1'b0;
    rd_cap    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cyc_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cyc_nxt = '0;
          if (rd_elig && (!wr_elig || last_wr)) begin
            state_nxt = RD_LOW;
            grant_rd  = 1'b1;
          end else if (wr_elig) begin
            state_nxt = WR_SETUP;
            grant_wr  = 1'b1;
          end
        end
        WR_SETUP: begin
          state_nxt = WR_LOW;
          cyc_nxt   = '0;
        end
        WR_LOW: begin
          if (cyc == 8'(WR_LOW_CYC - 1)) begin
            state_nxt = RECOVER;
            cyc_nxt   = '0;
            wr_done   = 1'b1;
          end else begin
            cyc_nxt = cyc + 8'd1;
          end
        end
        RD_LOW: begin
          if (cyc == 8'(RD_LOW_CYC - 1)) begin
            state_nxt = RECOVER;
            cyc_nxt   = '0;
            rd_cap    = 1'b1;
          end else begin
            cyc_nxt = cyc + 8'd1;
          end
        end
        RECOVER: begin
          if (cyc == 8'(RECOVER_CYC - 1)) begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
          end else begin
            cyc_nxt = cyc + 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
        end
      endcase
    end
  end

  // Pin outputs are registered from the next state so strobes never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cyc        <= '0;
      last_wr    <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state  <= state_nxt;
      cyc    <= cyc_nxt;
      wr_n_q <= (state_nxt != WR_LOW);
      rd_n_q <= (state_nxt != RD_LOW);
      oe_q   <= (state_nxt == WR_SETUP) || (state_nxt == WR_LOW);
      dout_q <= ((state_nxt == WR_SETUP) || (state_nxt == WR_LOW)) ? fr_byte : 8'h00;
      if (grant_rd)      last_wr <= 1'b0;
      else if (grant_wr) last_wr <= 1'b1;
      if (clear) begin
        rx_valid_q <= 1'b0;
      end else if (rd_cap) begin
        rx_data_q  <= bus.adbus_in;
        rx_valid_q <= 1'b1;
      end else if (pop) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ftdi_wr_n = wr_n_q;
  assign bus.ftdi_rd_n = rd_n_q;
  assign bus.adbus_oe  = oe_q;
  assign bus.adbus_out = dout_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;

endmodule

// File: tb/tb_ftdi_pkt_bridge.sv
// Scoreboard bench for ftdi_pkt_bridge with PKT_LEN=8 and a behavioural FTDI chip model.
module tb_ftdi_pkt_bridge;

  logic clock = 1'b0;
  logic reset_n, clear, rd_en, wr_en;

  ftdi_pkt_bridge_if #(.LW(4)) bus ();

  ftdi_pkt_bridge #(.PKT_LEN(8), .PAD_BYTE(8'h01), .SYNC_STAGES(2),
                    .WR_LOW_CYC(2), .RD_LOW_CYC(2), .RECOVER_CYC(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] wr_q[$];
  logic [7:0] rx_q[$];
  logic       grant_log[$];   // 1 = read, 0 = write
  int   wr_count  = 0;
  int   rd_pulses = 0;
  int   rd_w = 0, wr_w = 0;
  logic prev_wr = 1'b1, prev_rd = 1'b1;
  logic skip_w = 1'b0;
  logic [7:0] rx_seq = 8'h50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FTDI chip model and stream sinks, all sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_wr = 1'b1;
      prev_rd = 1'b1;
    end else begin
      if (!bus.ftdi_wr_n && !bus.ftdi_rd_n)
        check("strobe_excl", {30'd0, bus.ftdi_wr_n, bus.ftdi_rd_n}, 32'h2);
      if (prev_wr && !bus.ftdi_wr_n) begin
        wr_count++;
        wr_w = 1;
        grant_log.push_back(1'b0);
        check("wr_oe", bus.adbus_oe, 1);
        if (wr_q.size() == 0) check("wr_extra", wr_q.size(), 1);
        else check("wr_byte", bus.adbus_out, wr_q.pop_front());
      end else if (!bus.ftdi_wr_n) begin
        wr_w++;
      end else if (!prev_wr && !skip_w) begin
        check("wr_low_cyc", wr_w, 2);
      end
      if (prev_rd && !bus.ftdi_rd_n) begin
        rd_pulses++;
        rd_w = 1;
        grant_log.push_back(1'b1);
        bus.adbus_in = rx_seq;
        rx_q.push_back(rx_seq);
        rx_seq = rx_seq + 8'd1;
      end else if (!bus.ftdi_rd_n) begin
        rd_w++;
      end else if (!prev_rd) begin
        check("rd_low_cyc", rd_w, 2);
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (rx_q.size() == 0) check("rx_extra", rx_q.size(), 1);
        else check("rx_data", bus.rx_data, rx_q.pop_front());
      end
      prev_wr = bus.ftdi_wr_n;
      prev_rd = bus.ftdi_rd_n;
    end
  end

  task automatic send_packet(input int len, input logic [7:0] base);
    int n;
    int t;
    logic [7:0] b;
    n = (len > 8) ? 8 : len;
    for (int i = 0; i < 8; i++) begin
      b = base + 8'(i);
      wr_q.push_back((i < n) ? b : 8'h01);
    end
    @(posedge clock); #1;
    bus.pkt_start = 1'b1;
    bus.pkt_len   = 4'(len);
    @(posedge clock); #1;
    bus.pkt_start = 1'b0;
    check("busy_after_start", bus.pkt_busy, 1);
    for (int i = 0; i < n; i++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = base + 8'(i);
      t = 0;
      @(negedge clock);
      while (!bus.tx_ready && t < 500) begin
        @(negedge clock);
        t++;
      end
      if (t >= 500) check("tx_ready_timeout", bus.tx_ready, 1);
      @(posedge clock); #1;
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (i < 3000 && !(bus.pkt_busy == 1'b0 && wr_q.size() == 0)) begin
      @(negedge clock);
      i++;
    end
    check(tag, (i < 3000) ? 32'd1 : 32'd0, 1);
  endtask

  initial begin
    int base;
    int t;
    reset_n       = 1'b0;
    clear         = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    bus.txe_n     = 1'b1;
    bus.rxf_n     = 1'b1;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.pkt_start = 1'b0;
    bus.pkt_len   = 4'd0;
    bus.rx_ready  = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_wr_n",     bus.ftdi_wr_n, 1);
    check("rst_rd_n",     bus.ftdi_rd_n, 1);
    check("rst_oe",       bus.adbus_oe,  0);
    check("rst_adbus",    bus.adbus_out, 0);
    check("rst_rx_valid", bus.rx_valid,  0);
    check("rst_rx_data",  bus.rx_data,   0);
    check("rst_tx_ready", bus.tx_ready,  0);
    check("rst_busy",     bus.pkt_busy,  0);
    reset_n = 1'b1;

    // Short payload padded with PAD_BYTE
    bus.txe_n = 1'b0;
    wr_en     = 1'b1;
    base      = wr_count;
    send_packet(3, 8'hA1);
    wait_idle("pkt3_done");
    check("pkt3_busy", bus.pkt_busy, 0);
    repeat (20) @(negedge clock);
    check("pkt3_writes", wr_count - base, 8);

    // Zero-length payload
    base = wr_count;
    send_packet(0, 8'h00);
    wait_idle("pkt0_done");
    check("pkt0_writes", wr_count - base, 8);

    // Oversized length clamps to PKT_LEN; a pkt_start while busy is ignored
    base = wr_count;
    send_packet(15, 8'hB0);
    check("pkt15_tx_ready", bus.tx_ready, 0);
    bus.pkt_start = 1'b1;
    bus.pkt_len   = 4'd2;
    @(posedge clock); #1;
    bus.pkt_start = 1'b0;
    wait_idle("pkt15_done");
    repeat (20) @(negedge clock);
    check("pkt15_writes", wr_count - base, 8);

    // Read/write alternation with both sides pending
    bus.rxf_n = 1'b0;
    wr_en     = 1'b0;
    repeat (4) @(posedge clock);
    grant_log.delete();
    fork
      send_packet(8, 8'hC0);
      begin
        repeat (6) @(posedge clock);
        #1;
        rd_en = 1'b1;
        wr_en = 1'b1;
      end
    join
    wait_idle("alt_done");
    rd_en = 1'b0;
    repeat (20) @(negedge clock);
    check("alt_rx_drain", rx_q.size(), 0);
    check("alt_g0", grant_log[0], 1);
    check("alt_g1", grant_log[1], 0);
    check("alt_g2", grant_log[2], 1);
    check("alt_g3", grant_log[3], 0);

    // rx slot back-pressure
    wr_en        = 1'b0;
    bus.rx_ready = 1'b0;
    rd_pulses    = 0;
    @(posedge clock); #1;
    rd_en = 1'b1;
    repeat (40) @(posedge clock);
    check("bp_single_read", rd_pulses, 1);
    #1;
    bus.rx_ready = 1'b1;
    repeat (40) @(posedge clock);
    check("bp_resume", (rd_pulses > 3) ? 32'd1 : 32'd0, 1);
    #1;
    rd_en = 1'b0;
    repeat (20) @(negedge clock);
    check("bp_rx_drain", rx_q.size(), 0);

    // clear during WR_LOW of the second byte
    wr_en = 1'b1;
    base  = wr_count;
    wr_q.push_back(8'h01);
    wr_q.push_back(8'h01);
    @(posedge clock); #1;
    bus.pkt_start = 1'b1;
    bus.pkt_len   = 4'd0;
    @(posedge clock); #1;
    bus.pkt_start = 1'b0;
    t = 0;
    while (wr_count != base + 2 && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("clr_reach_byte2", wr_count - base, 2);
    skip_w = 1'b1;
    clear  = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("clr_wr_n", bus.ftdi_wr_n, 1);
    check("clr_rd_n", bus.ftdi_rd_n, 1);
    check("clr_oe",   bus.adbus_oe,  0);
    check("clr_busy", bus.pkt_busy,  0);
    repeat (20) @(negedge clock);
    skip_w = 1'b0;
    check("clr_no_more_writes", wr_count - base, 2);
    base = wr_count;
    send_packet(3, 8'hD1);
    wait_idle("clr_new_pkt_done");
    check("clr_new_pkt_writes", wr_count - base, 8);

    // Reset in the middle of RD_LOW
    wr_en = 1'b0;
    rd_en = 1'b1;
    t = 0;
    @(negedge clock);
    while (bus.ftdi_rd_n && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("rst_mid_reach_rd", bus.ftdi_rd_n, 0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    rd_en   = 1'b0;
    #1;
    check("rst_mid_rd_n",     bus.ftdi_rd_n, 1);
    check("rst_mid_rx_valid", bus.rx_valid,  0);
    rx_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    grant_log.delete();
    base = wr_count;
    fork
      send_packet(1, 8'hE0);
      begin
        repeat (6) @(posedge clock);
        #1;
        rd_en = 1'b1;
        wr_en = 1'b1;
      end
    join
    wait_idle("rst_mid_pkt_done");
    rd_en = 1'b0;
    repeat (20) @(negedge clock);
    check("rst_mid_g0", grant_log[0], 1);
    check("rst_mid_g1", grant_log[1], 0);
    check("rst_mid_writes", wr_count - base, 8);
    check("rst_mid_rx_drain", rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
